adc_lane_align: RTL
===================

Name: adc_lane_align

Overview:
- Per-lane deskew and DDR half-cycle slip correction for parallel ADC data that has already been captured and moved into the clk240 domain as rise/fall word pairs (ad1/ad2).
- During a training window the ADC drives its "all lanes identical" test sequence.
- Lanes 1..LANES-1 are searched over cycle delay and edge slip until each matches reference lane 0.
- Aligned words then stream out with a valid flag; sits between the capture/CDC stage and sample processing.

Parameters:
- LANES, 8, number of data lanes (2..16); lane 0 is the reference.
- MAX_SKEW, 4, maximum per-lane delay in valid samples; the search range is 0..MAX_SKEW.
- LOCK_CNT, 64, consecutive valid matching samples required to lock a lane (>=2).
- SETTLE_CNT, 8, valid samples to wait after a config change before checking (must be >= MAX_SKEW+2).

Ports:
- clk240  in  1  system sample clock.
- nRST  in  1  asynchronous active-low reset.
- din1  in  LANES  rising-edge bit per lane.
- din2  in  LANES  falling-edge bit per lane.
- din_valid  in  1  din1/din2 qualified this cycle.
- train_start  in  1  single-cycle pulse that starts or restarts training.
- dout1  out  LANES  aligned rising-edge bits.
- dout2  out  LANES  aligned falling-edge bits.
- dout_valid  out  1  dout qualified.
- train_busy  out  1  training in progress.
- locked  out  1  all lanes locked; level output.
- train_err  out  1  training ended with at least one lane unresolved.
- fail_mask  out  LANES  lanes that exhausted their search (bit 0 is always 0).

Behaviour:
- Reset (nRST low, asynchronous): all outputs 0, FSM in IDLE, every lane config set to d=0, s=0, delay lines cleared.
- Per lane: a shift register of depth MAX_SKEW+1 holding (din1,din2), advancing only when din_valid=1.
  - Tap d selects the pair delayed by d valid samples.
  - s=1 forms the pair as (din2 of the sample before tap d, din1 of tap d); s=0 passes the tap pair unchanged.
- Lane 0 is fixed at d=MAX_SKEW/2 (integer division), s=0, and is never searched.
- Config order per lane: (d=0,s=0), (0,1), (1,0), ... (MAX_SKEW,1), giving 2*(MAX_SKEW+1) configs.
- Outputs are registered: dout1/dout2 update and dout_valid=locked&din_valid, one cycle after the din_valid sample.
- FSM states:
  - IDLE: waits for train_start.
  - SETTLE: counts SETTLE_CNT valid samples, then goes to CHECK and clears the window counter, per-lane mismatch flags and the ref_toggle flag.
  - CHECK: counts LOCK_CNT valid samples.
    - For each unlocked lane, a mismatch flag is set if its aligned pair differs from lane 0's aligned pair on any valid sample.
    - ref_toggle is set if lane 0's aligned pair differs from its previous value.
  - EVAL: one cycle.
    - An unlocked lane with no mismatch locks, but only if ref_toggle=1; its config is then held.
    - Other unlocked lanes advance config. A lane already on its last config is marked in fail_mask and stops.
    - If ref_toggle=0, no lane locks or advances; the window repeats via SETTLE.
    - Exits: all lanes 1..LANES-1 locked goes to DONE with locked=1. Otherwise, if every unlocked lane has failed, go to DONE with train_err=1. Otherwise return to SETTLE.
  - DONE: holds results until the next train_start.
- train_start entry:
  - From any state it clears locked, train_err, fail_mask and all lane locks, resets every config to (0,0), and enters SETTLE.
  - train_busy=1 from the cycle after train_start until DONE is entered.
  - train_start during busy restarts the search with no result output.
- din_valid=0 freezes all counters and delay lines. The FSM stays in its current state, except that EVAL always completes in one cycle.
- Bounds:
  - Worst-case training length is 2*(MAX_SKEW+1)*(SETTLE_CNT+LOCK_CNT)+EVAL cycles when din_valid is held high and the reference toggles.
  - Counter widths are clog2 of the maximum count plus 1, and counters do not wrap.
- Reset mid-training returns to the reset state; no auto-restart.

Test Plan:
- Reset, then train_start with all lanes carrying an identical 16-sample ramp pattern and zero skew. Lanes 1..7 must lock at d=2, s=0, locked=1, dout1 equal to din1 delayed by 3 valid cycles, and train_err=0.
- Lane 3 advanced by 1 sample and lane 5 given a half-cycle slip. Lane 3 must lock at (3,0), lane 5 at (2,1), and every dout lane must carry identical bits each cycle after lock.
- Lane 6 driven with an inverted pattern. Expect train_err=1, fail_mask=8'h40, locked=0, train_busy falling after 10 windows.
- Constant pattern 0 on all lanes. The FSM must loop SETTLE/CHECK/EVAL with train_busy=1 and no lock; a later switch to toggling data must then lock.
- din_valid toggled at a 1:3 duty during training. Same lock result as the first scenario; locked must rise after exactly (SETTLE_CNT+LOCK_CNT) valid samples plus EVAL, per window.
- train_start asserted during CHECK, then nRST pulsed low mid-SETTLE. In both cases outputs must clear: locked=0, train_busy must follow the rules above, and after the reset all outputs must be 0 immediately.

Source files
------------

// File: rtl/adc_lane_align_if.sv
// Bus bundle for adc_lane_align: raw per-lane rise/fall bits in, aligned bits and training status out.
// Latency: none, wires only.
// Backpressure: none; data is qualified by din_valid on the way in and dout_valid on the way out.
interface adc_lane_align_if #(
   parameter int LANES = 8
);
   logic [LANES-1:0] din1;
   logic [LANES-1:0] din2;
   logic             din_valid;
   logic             train_start;
   logic [LANES-1:0] dout1;
   logic [LANES-1:0] dout2;
   logic             dout_valid;
   logic             train_busy;
   logic             locked;
   logic             train_err;
   logic [LANES-1:0] fail_mask;

   modport master (
      output din1, din2, din_valid, train_start,
      input  dout1, dout2, dout_valid, train_busy, locked, train_err, fail_mask
   );

   modport slave (
      input  din1, din2, din_valid, train_start,
      output dout1, dout2, dout_valid, train_busy, locked, train_err, fail_mask
   );
endinterface

// File: rtl/adc_lane_align.sv
// Per-lane deskew and DDR half-cycle slip search against reference lane 0, then aligned streaming.
// Latency: dout carries the lane-0 sample MAX_SKEW/2+1 valid samples old, registered on the din_valid edge.
// Backpressure: none; din_valid=0 freezes delay lines, counters and search (EVAL still completes in one cycle).
module adc_lane_align #(
   parameter int LANES      = 8,
   parameter int MAX_SKEW   = 4,
   parameter int LOCK_CNT   = 64,
   parameter int SETTLE_CNT = 8
) (
   input  logic            clk240,
   input  logic            nRST,
   adc_lane_align_if.slave bus
);
   // One extra stage beyond MAX_SKEW so the slipped pair at the deepest tap has an older sample to borrow din2 from.
   localparam int DEPTH = MAX_SKEW + 2;
   localparam int TAP_W = $clog2(DEPTH);
   localparam int NCFG  = 2 * (MAX_SKEW + 1);
   localparam int CFG_W = $clog2(NCFG);
   localparam int MAXC  = (LOCK_CNT > SETTLE_CNT) ? LOCK_CNT : SETTLE_CNT;
   localparam int CNT_W = $clog2(MAXC + 1);

   // Config encoding is {d, s}, so stepping the search order is a plain increment.
   localparam logic [CFG_W-1:0] REF_CFG  = CFG_W'(2 * (MAX_SKEW / 2));
   localparam logic [CFG_W-1:0] LAST_CFG = CFG_W'(NCFG - 1);
   // Lane 0 is the reference and is treated as permanently locked.
   localparam logic [LANES-1:0] LANE0    = {{(LANES-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, SETTLE, CHECK, EVAL, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CFG_W-1:0] cfg [LANES];
   logic [LANES-1:0] lane_lock;
   logic [LANES-1:0] lane_fail;
   logic [LANES-1:0] mism;
   logic             ref_toggle;
   logic [1:0]       ref_prev;
   logic             busy_q;
   logic             locked_q;
   logic             err_q;

   logic [LANES-1:0] sr1 [DEPTH];
   logic [LANES-1:0] sr2 [DEPTH];
   logic [LANES-1:0] dout1_q;
   logic [LANES-1:0] dout2_q;
   logic             dout_vld_q;

   logic [LANES-1:0] al1;
   logic [LANES-1:0] al2;
   logic [LANES-1:0] diff;
   logic [TAP_W-1:0] tap;
   logic [LANES-1:0] ev_lock;
   logic [LANES-1:0] ev_fail;
   logic [LANES-1:0] ev_adv;
   logic [LANES-1:0] lock_nxt;
   logic [LANES-1:0] fail_nxt;

   // Tap/slip selection: s=1 pairs the older sample's din2 with the tap sample's din1.
   always_comb begin
      al1 = '0;
      al2 = '0;
      tap = '0;
      for (int k = 0; k < LANES; k++) begin
         tap = TAP_W'(cfg[k][CFG_W-1:1]);
         if (cfg[k][0]) begin
            al1[k] = sr2[tap + TAP_W'(1)][k];
            al2[k] = sr1[tap][k];
         end else begin
            al1[k] = sr1[tap][k];
            al2[k] = sr2[tap][k];
         end
      end
   end

   assign diff = (al1 ^ {LANES{al1[0]}}) | (al2 ^ {LANES{al2[0]}});

   // End-of-window verdict per unresolved lane: clean window locks, otherwise step or give up on the last config.
   always_comb begin
      ev_lock = '0;
      ev_fail = '0;
      ev_adv  = '0;
      for (int k = 0; k < LANES; k++) begin
         if (!lane_lock[k] && !lane_fail[k]) begin
            if (!mism[k])
               ev_lock[k] = 1'b1;
            else if (cfg[k] == LAST_CFG)
               ev_fail[k] = 1'b1;
            else
               ev_adv[k] = 1'b1;
         end
      end
      lock_nxt = lane_lock | ev_lock;
      fail_nxt = lane_fail | ev_fail;
   end

   // Delay lines and registered aligned output, both advancing only on valid samples.
   always_ff @(posedge clk240 or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr1[i] <= '0;
            sr2[i] <= '0;
         end
         dout1_q    <= '0;
         dout2_q    <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         dout_vld_q <= locked_q & bus.din_valid;
         if (bus.din_valid) begin
            sr1[0] <= bus.din1;
            sr2[0] <= bus.din2;
            for (int i = 1; i < DEPTH; i++) begin
               sr1[i] <= sr1[i-1];
               sr2[i] <= sr2[i-1];
            end
            dout1_q <= al1;
            dout2_q <= al2;
         end
      end
   end

   // Training sequencer: window counting, per-lane config search and status flags.
   always_ff @(posedge clk240 or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         cnt        <= '0;
         lane_lock  <= LANE0;
         lane_fail  <= '0;
         mism       <= '0;
         ref_toggle <= 1'b0;
         ref_prev   <= 2'b00;
         busy_q     <= 1'b0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         for (int k = 0; k < LANES; k++)
            cfg[k] <= (k == 0) ? REF_CFG : '0;
      end else begin
         if (bus.din_valid)
            ref_prev <= {al1[0], al2[0]};
         if (bus.train_start) begin
            state      <= SETTLE;
            cnt        <= '0;
            lane_lock  <= LANE0;
            lane_fail  <= '0;
            mism       <= '0;
            ref_toggle <= 1'b0;
            busy_q     <= 1'b1;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            for (int k = 0; k < LANES; k++)
               cfg[k] <= (k == 0) ? REF_CFG : '0;
         end else begin
            case (state)
               SETTLE: begin
                  if (bus.din_valid) begin
                     if (cnt == CNT_W'(SETTLE_CNT - 1)) begin
                        state      <= CHECK;
                        cnt        <= '0;
                        mism       <= '0;
                        ref_toggle <= 1'b0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               CHECK: begin
                  if (bus.din_valid) begin
                     mism <= mism | diff;
                     if ({al1[0], al2[0]} != ref_prev)
                        ref_toggle <= 1'b1;
                     if (cnt == CNT_W'(LOCK_CNT - 1)) begin
                        state <= EVAL;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               EVAL: begin
                  state <= SETTLE;
                  // A static reference proves nothing, so the window is simply repeated.
                  if (ref_toggle) begin
                     lane_lock <= lock_nxt;
                     lane_fail <= fail_nxt;
                     for (int k = 0; k < LANES; k++)
                        if (ev_adv[k])
                           cfg[k] <= cfg[k] + 1'b1;
                     if (&lock_nxt) begin
                        state    <= DONE;
                        locked_q <= 1'b1;
                        busy_q   <= 1'b0;
                     end else if (&(lock_nxt | fail_nxt)) begin
                        state  <= DONE;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.dout1      = dout1_q;
   assign bus.dout2      = dout2_q;
   assign bus.dout_valid = dout_vld_q;
   assign bus.train_busy = busy_q;
   assign bus.locked     = locked_q;
   assign bus.train_err  = err_q;
   assign bus.fail_mask  = lane_fail;
endmodule
